// File: rtl/apb_slave_regfile.sv
// APB responder with a DEPTH-word register file and programmable wait states.
// Optional error responses on Pslverr are enabled by defining APB_SLVERR_EN.
`timescale 1ns/1ps
module apb_slave_regfile #(
    parameter int unsigned SEL_INDEX   = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [31:0] SPAN   = 32'(DEPTH * 4);
    localparam logic        ST_IDLE   = 1'b0;
    localparam logic        ST_ACCESS = 1'b1;

`ifdef APB_SLVERR_EN
    localparam logic        ERR_EN    = 1'b1;
    localparam logic [31:0] BAD_RDATA = 32'hDEAD_BEEF;
`else
    localparam logic        ERR_EN    = 1'b0;
    localparam logic [31:0] BAD_RDATA = 32'h0;
`endif

    logic             state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ok_q, ok_d;
    logic [31:0]      prdata_q, prdata_d;
    logic [31:0]      regs_q [DEPTH];
    logic             wr_en;

    logic             sel, setup;
    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_range, aligned, addr_ok;
    logic             unused_sel;

    assign sel        = Pselx[SEL_INDEX];
    assign setup      = sel & ~Penable;
    assign unused_sel = ^Pselx;

    // Unsigned offset: an address below BASE_ADDR wraps to a huge value and fails the range test.
    assign off      = Paddr - BASE_ADDR;
    assign idx      = off[2 +: IDX_W];
    assign in_range = (off < SPAN);
    assign aligned  = (Paddr[1:0] == 2'b00);
    assign addr_ok  = in_range & aligned;

    assign Pready  = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign Pslverr = ERR_EN & Pready & ~ok_q;
    assign Prdata  = prdata_q;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        idx_d    = idx_q;
        ok_d     = ok_q;
        prdata_d = prdata_q;
        wr_en    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (setup) begin
                state_d = ST_ACCESS;
                cnt_d   = 4'(WAIT_STATES);
                write_d = Pwrite;
                idx_d   = idx;
                ok_d    = addr_ok;
                if (!Pwrite) begin
                    prdata_d = addr_ok ? regs_q[idx] : BAD_RDATA;
                end
            end
        end else begin
            if (!(sel && Penable)) begin
                state_d = ST_IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = ST_IDLE;
                wr_en   = write_q & ok_q;
            end
        end
    end

    // NOTE: the register file sits under the async reset because it must read back as zero after reset.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            ok_q     <= 1'b0;
            prdata_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            ok_q     <= ok_d;
            prdata_q <= prdata_d;
            if (wr_en) begin
                regs_q[idx_q] <= Pwdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: two responders share the bus, one with a wait state (Pselx[0]) and one without (Pselx[1]).
`timescale 1ns/1ps
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef APB_SLVERR_EN
    localparam logic        ERR = 1'b1;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
`else
    localparam logic        ERR = 1'b0;
    localparam logic [31:0] BAD = 32'h0;
`endif

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite;
    logic [31:0] Paddr, Pwdata;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int checks = 0;
    int errors = 0;

    always #5 Hclk = ~Hclk;

    apb_slave_regfile #(.SEL_INDEX(0), .BASE_ADDR(BASE), .DEPTH(16), .WAIT_STATES(1)) dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0)
    );

    apb_slave_regfile #(.SEL_INDEX(1), .BASE_ADDR(BASE), .DEPTH(16), .WAIT_STATES(0)) dut1 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata1), .Pready(pready1), .Pslverr(pslverr1)
    );

    typedef struct {
        int          s;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
        logic        b2b;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_cyc, input logic b2b);
        vec_t v;
        v.s = s; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err; v.exp_cyc = exp_cyc; v.b2b = b2b;
        return v;
    endfunction

    task automatic idle();
        Pselx   = 3'b000;
        Penable = 1'b0;
        @(posedge Hclk); #1;
    endtask

    // Starts just after a rising edge; returns just after the completion edge.
    task automatic xfer(input int s, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int cyc, output logic other_rdy);
        logic rdy;
        Pselx   = 3'(1 << s);
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = wdata;
        rdata = '0; err = 1'b0; cyc = 0; other_rdy = 1'b0;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge Hclk);
            cyc++;
            rdy = (s == 0) ? pready0 : pready1;
            if (((s == 0) ? pready1 : pready0) === 1'b1) other_rdy = 1'b1;
            if (rdy === 1'b1) begin
                rdata = (s == 0) ? prdata0 : prdata1;
                err   = (s == 0) ? pslverr0 : pslverr1;
                break;
            end
        end
        @(posedge Hclk); #1;
    endtask

    task automatic read_check(input string name, input int s, input logic [31:0] addr,
                              input logic [31:0] exp);
        logic [31:0] rd;
        logic        er, orr;
        int          cy;
        xfer(s, 1'b0, addr, 32'h0, rd, er, cy, orr);
        idle();
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, orr;
        int          cy;

        Hreset = 1'b1; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
        repeat (3) @(posedge Hclk);
        #1;
        check("rst_prdata", prdata0, 32'h0);
        check("rst_pready", {31'h0, pready0}, 32'h0);
        check("rst_pslverr", {31'h0, pslverr0}, 32'h0);
        check("rst_pready1", {31'h0, pready1}, 32'h0);
        Hreset = 1'b0;
        @(posedge Hclk); #1;

        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(0, 1'b0, BASE + 32'(4 * i), 32'h0, 32'h0, 1'b0, 2, 1'b0));
        end
        vecs.push_back(mk(1, 1'b0, BASE,          32'h0,         32'h0,         1'b0, 1, 1'b0));
        vecs.push_back(mk(0, 1'b1, BASE + 32'd4,  32'hA5A5_0001, 32'h0,         1'b0, 2, 1'b0));
        vecs.push_back(mk(0, 1'b0, BASE + 32'd4,  32'h0,         32'hA5A5_0001, 1'b0, 2, 1'b0));
        vecs.push_back(mk(1, 1'b1, BASE + 32'd8,  32'h5A5A_1234, 32'h0,         1'b0, 1, 1'b1));
        vecs.push_back(mk(1, 1'b0, BASE + 32'd8,  32'h0,         32'h5A5A_1234, 1'b0, 1, 1'b0));
        vecs.push_back(mk(0, 1'b1, BASE + 32'd60, 32'h0F0F_F00F, 32'h0,         1'b0, 2, 1'b0));
        vecs.push_back(mk(0, 1'b1, BASE + 32'd64, 32'h1111_1111, 32'h0,         ERR,  2, 1'b0));
        vecs.push_back(mk(0, 1'b0, BASE - 32'd4,  32'h0,         BAD,           ERR,  2, 1'b0));
        vecs.push_back(mk(0, 1'b1, BASE - 32'd4,  32'h2222_2222, 32'h0,         ERR,  2, 1'b0));
        vecs.push_back(mk(0, 1'b0, BASE + 32'd60, 32'h0,         32'h0F0F_F00F, 1'b0, 2, 1'b0));
        vecs.push_back(mk(0, 1'b0, BASE,          32'h0,         32'h0,         1'b0, 2, 1'b0));
        vecs.push_back(mk(0, 1'b1, BASE + 32'd2,  32'hFFFF_FFFF, 32'h0,         ERR,  2, 1'b0));
        vecs.push_back(mk(0, 1'b0, BASE,          32'h0,         32'h0,         1'b0, 2, 1'b0));
        vecs.push_back(mk(0, 1'b0, BASE + 32'd6,  32'h0,         BAD,           ERR,  2, 1'b0));
        vecs.push_back(mk(0, 1'b0, BASE + 32'd4,  32'h0,         32'hA5A5_0001, 1'b0, 2, 1'b0));

        foreach (vecs[k]) begin
            xfer(vecs[k].s, vecs[k].wr, vecs[k].addr, vecs[k].wdata, rd, er, cy, orr);
            if (!vecs[k].b2b) idle();
            check($sformatf("v%0d_cycles", k), 32'(cy), 32'(vecs[k].exp_cyc));
            check($sformatf("v%0d_slverr", k), {31'h0, er}, {31'h0, vecs[k].exp_err});
            check($sformatf("v%0d_other_ready", k), {31'h0, orr}, 32'h0);
            if (!vecs[k].wr) check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
        end

        // Prdata holds the last read value through a write and idle cycles.
        xfer(0, 1'b1, BASE + 32'd20, 32'h3333_3333, rd, er, cy, orr);
        idle();
        idle();
        check("hold_prdata", prdata0, 32'hA5A5_0001);

        // Penable without a setup phase is ignored.
        Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b0; Paddr = BASE;
        @(negedge Hclk);
        check("idle_penable_a", {31'h0, pready0}, 32'h0);
        @(negedge Hclk);
        check("idle_penable_b", {31'h0, pready0}, 32'h0);
        #6;
        idle();

        // Dropping select before completion aborts the write.
        Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'd16; Pwdata = 32'hDEAD_0004;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(negedge Hclk);
        check("abort_wait", {31'h0, pready0}, 32'h0);
        @(posedge Hclk); #1;
        Pselx = 3'b000; Penable = 1'b0;
        @(posedge Hclk); #1;
        check("abort_ready", {31'h0, pready0}, 32'h0);
        check("abort_prdata", prdata0, 32'hA5A5_0001);
        read_check("abort_rd16", 0, BASE + 32'd16, 32'h0);

        // Reset during the wait state of a write.
        read_check("pre_rst_rd4", 0, BASE + 32'd4, 32'hA5A5_0001);
        Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'd12; Pwdata = 32'h7777_7777;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(negedge Hclk);
        #1 Hreset = 1'b1;
        #1;
        check("midrst_prdata", prdata0, 32'h0);
        check("midrst_pready", {31'h0, pready0}, 32'h0);
        check("midrst_pslverr", {31'h0, pslverr0}, 32'h0);
        Pselx = 3'b000; Penable = 1'b0;
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        @(posedge Hclk); #1;
        read_check("post_rst_rd12", 0, BASE + 32'd12, 32'h0);
        read_check("post_rst_rd4", 0, BASE + 32'd4, 32'h0);
        read_check("post_rst_rd60", 0, BASE + 32'd60, 32'h0);
        read_check("post_rst_dut1_rd8", 1, BASE + 32'd8, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
